mem_port_arbiter: RTL

- Shares one single-ported unified memory between the pipeline's instruction-fetch requester and its data (load/store) requester.
- Arbitrates between the two, sequences exactly one outstanding memory transaction at a time, and routes each response back to its owner.
- Data accesses have priority; a starvation guard bounds how long fetch can be locked out.
- A flush input discards a fetch response that belongs to a squashed fetch after a taken branch or jump.

---
 rtl/mem_port_arbiter_if.sv | 57 +++++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the three buses around the unified-memory arbiter:
//   fetch requester : if_req_valid/addr/ready, if_rsp_valid/data, if_flush
//   data requester  : dm_req_valid/addr/we/wdata/be/ready, dm_rsp_valid/rdata
//   memory port     : mem_req_valid/addr/we/wdata/be/ready, mem_rsp_valid/rdata
// Modports:
//   slave  - the arbiter: serves both requesters and drives the memory port.
//   master - the environment: requesters plus the memory device.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if;
    // Fetch requester
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        if_flush;

    // Data requester
    logic        dm_req_valid;
    logic [31:0] dm_req_addr;
    logic        dm_req_we;
    logic [31:0] dm_req_wdata;
    logic [3:0]  dm_req_be;
    logic        dm_req_ready;
    logic        dm_rsp_valid;
    logic [31:0] dm_rsp_rdata;

    // Memory port
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_we;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    modport slave (
        input  if_req_valid, if_req_addr, if_flush,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        input  dm_req_valid, dm_req_addr, dm_req_we, dm_req_wdata, dm_req_be,
        output dm_req_ready, dm_rsp_valid, dm_rsp_rdata,
        output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_be,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport master (
        output if_req_valid, if_req_addr, if_flush,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        output dm_req_valid, dm_req_addr, dm_req_we, dm_req_wdata, dm_req_be,
        input  dm_req_ready, dm_rsp_valid, dm_rsp_rdata,
        input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_be,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch and data
// (load/store). One transaction is outstanding at a time; data has priority,
// but after STARVE_LIMIT consecutive data grants with fetch waiting, fetch
// wins the next arbitration. if_flush discards the response of a squashed
// fetch.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - mem_port_arbiter_if.slave (fetch, data and memory buses)
// Parameters:
//   STARVE_LIMIT - max consecutive data grants while fetch waits (1..15)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_I,
        WAIT_D
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic        drop_q, drop_d;
    logic        if_rsp_valid_q, if_rsp_valid_d;
    logic [31:0] if_rsp_data_q, if_rsp_data_d;
    logic        dm_rsp_valid_q, dm_rsp_valid_d;
    logic [31:0] dm_rsp_rdata_q, dm_rsp_rdata_d;

    logic        can_issue;
    logic        fetch_wins;
    logic        data_wins;
    logic        if_accept;
    logic        dm_accept;

    // Arbitration. Requests are only issued from IDLE and never during reset.
    assign can_issue  = (state_q == IDLE) && !rst;
    assign fetch_wins = bus.if_req_valid && (!bus.dm_req_valid || (streak_q == LIMIT));
    assign data_wins  = bus.dm_req_valid && !fetch_wins;
    assign if_accept  = can_issue && fetch_wins && bus.mem_req_ready;
    assign dm_accept  = can_issue && data_wins  && bus.mem_req_ready;

    // Memory request mirrors the winner; a fetch is a full-word read.
    assign bus.mem_req_valid = can_issue && (bus.if_req_valid || bus.dm_req_valid);
    assign bus.mem_req_addr  = data_wins ? bus.dm_req_addr  : bus.if_req_addr;
    assign bus.mem_req_we    = data_wins && bus.dm_req_we;
    assign bus.mem_req_wdata = data_wins ? bus.dm_req_wdata : '0;
    assign bus.mem_req_be    = data_wins ? bus.dm_req_be    : 4'hF;
    assign bus.if_req_ready  = can_issue && fetch_wins && bus.mem_req_ready;
    assign bus.dm_req_ready  = can_issue && data_wins  && bus.mem_req_ready;

    assign bus.if_rsp_valid  = if_rsp_valid_q;
    assign bus.if_rsp_data   = if_rsp_data_q;
    assign bus.dm_rsp_valid  = dm_rsp_valid_q;
    assign bus.dm_rsp_rdata  = dm_rsp_rdata_q;

    always_comb begin
        state_d        = state_q;
        streak_d       = streak_q;
        drop_d         = drop_q;
        if_rsp_valid_d = 1'b0;
        if_rsp_data_d  = if_rsp_data_q;
        dm_rsp_valid_d = 1'b0;
        dm_rsp_rdata_d = dm_rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (dm_accept) begin
                    state_d = WAIT_D;
                    // Streak only grows while fetch is actually being held off.
                    if (bus.if_req_valid) begin
                        streak_d = (streak_q >= LIMIT) ? LIMIT : streak_q + 4'd1;
                    end else begin
                        streak_d = '0;
                    end
                end else if (if_accept) begin
                    state_d  = WAIT_I;
                    streak_d = '0;
                    drop_d   = bus.if_flush;
                end
            end
            WAIT_I: begin
                if (bus.mem_rsp_valid) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    // A flush on the response cycle itself also squashes it.
                    if (!drop_q && !bus.if_flush) begin
                        if_rsp_valid_d = 1'b1;
                        if_rsp_data_d  = bus.mem_rsp_rdata;
                    end
                end else if (bus.if_flush) begin
                    drop_d = 1'b1;
                end
            end
            WAIT_D: begin
                if (bus.mem_rsp_valid) begin
                    state_d        = IDLE;
                    dm_rsp_valid_d = 1'b1;
                    dm_rsp_rdata_d = bus.mem_rsp_rdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            streak_q       <= '0;
            drop_q         <= 1'b0;
            if_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= '0;
            dm_rsp_valid_q <= 1'b0;
            dm_rsp_rdata_q <= '0;
        end else begin
            state_q        <= state_d;
            streak_q       <= streak_d;
            drop_q         <= drop_d;
            if_rsp_valid_q <= if_rsp_valid_d;
            if_rsp_data_q  <= if_rsp_data_d;
            dm_rsp_valid_q <= dm_rsp_valid_d;
            dm_rsp_rdata_q <= dm_rsp_rdata_d;
        end
    end

endmodule
